// File: rtl/cache_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cache_arb_pkg
// Purpose  : Shared types and helpers for the cache port arbiter slice.
//            - arb_state_e : arbiter FSM state encoding
//            - arb_req_t   : request latched at grant time (rd_wr, addr,
//                            wdata, owner)
//            - idx_width() : index width for an N-entry select (min 1 bit)
// Revision : 1.0 - initial release
// ============================================================================
package cache_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } arb_state_e;

  // Field widths of the latched request. Address/data fields are sized for
  // the widest bus this slice is built with; narrower buses occupy the LSBs.
  localparam int c_ARB_ADDR_W  = 32;
  localparam int c_ARB_DATA_W  = 32;
  localparam int c_ARB_OWNER_W = 8;

  // Width of an index selecting one of n items; never narrower than 1 bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  typedef struct packed {
    logic                     rd_wr;
    logic [c_ARB_ADDR_W-1:0]  addr;
    logic [c_ARB_DATA_W-1:0]  wdata;
    logic [c_ARB_OWNER_W-1:0] owner;
  } arb_req_t;

endpackage
`default_nettype wire

// File: rtl/cache_port_arbiter_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter
// Purpose  : Combinational round-robin pick. Searches req_valid starting at
//            last_grant+1 (mod N) and returns the first requester found.
// Ports    : req_valid  [N-1:0]     in  requests
//            last_grant [IDX_W-1:0] in  index granted most recently
//            grant      [N-1:0]     out one-hot grant (zero if none valid)
//            grant_idx  [IDX_W-1:0] out index of the grant
//            any_valid              out at least one request present
// Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
  parameter int N     = 2,
  parameter int IDX_W = 1
) (
  input  logic [N-1:0]     req_valid,
  input  logic [IDX_W-1:0] last_grant,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             any_valid
);

  logic [IDX_W-1:0] w_cand;

  always_comb begin
    w_cand    = '0;
    grant_idx = '0;
    any_valid = 1'b0;
    // Offsets 1..N visit every requester once, last_grant itself last.
    for (int k = 1; k <= N; k++) begin
      w_cand = IDX_W'((int'(last_grant) + k) % N);
      if (!any_valid && req_valid[w_cand]) begin
        any_valid = 1'b1;
        grant_idx = w_cand;
      end
    end
    grant            = '0;
    grant[grant_idx] = any_valid;
  end

endmodule
`default_nettype wire

// File: rtl/cache_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : cache_port_arbiter
// Purpose  : Shares one TopCache access port among N_REQ requesters.
//            Grants one request at a time (round-robin), drives the cache
//            inputs for CACHE_LAT cycles, captures read data / hit flag and
//            returns a one-cycle response pulse to the owner. Keeps
//            saturating hit/miss counters.
// Ports    : clk, reset (async, active-high)
//            req_valid/req_ready/req_rd_wr/req_addr/req_wdata - requests
//            rsp_valid/rsp_rdata/rsp_hit                      - responses
//            cache_req_valid/cache_rd_wr/cache_address/
//            cache_write_data/cache_read_data/cache_hit_miss  - cache port
//            clear_stats, hit_cnt, miss_cnt                   - statistics
// Revision : 1.0 - initial release
// ============================================================================
module cache_port_arbiter
  import cache_arb_pkg::*;
#(
  parameter int N_REQ     = 2,
  parameter int ADDR_W    = 32,   // must not exceed c_ARB_ADDR_W
  parameter int DATA_W    = 32,   // must not exceed c_ARB_DATA_W
  parameter int CACHE_LAT = 1,
  parameter int CNT_W     = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N_REQ-1:0]        req_valid,
  output logic [N_REQ-1:0]        req_ready,
  input  logic [N_REQ-1:0]        req_rd_wr,
  input  logic [N_REQ*ADDR_W-1:0] req_addr,
  input  logic [N_REQ*DATA_W-1:0] req_wdata,
  output logic [N_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]       rsp_rdata,
  output logic                    rsp_hit,
  output logic                    cache_req_valid,
  output logic                    cache_rd_wr,
  output logic [ADDR_W-1:0]       cache_address,
  output logic [DATA_W-1:0]       cache_write_data,
  input  logic [DATA_W-1:0]       cache_read_data,
  input  logic                    cache_hit_miss,
  input  logic                    clear_stats,
  output logic [CNT_W-1:0]        hit_cnt,
  output logic [CNT_W-1:0]        miss_cnt
);

  localparam int IDX_W = idx_width(N_REQ);
  localparam int LAT_W = idx_width(CACHE_LAT);

  arb_state_e        r_state;
  arb_state_e        w_state_nxt;
  arb_req_t          r_req;
  arb_req_t          w_pick;
  logic [IDX_W-1:0]  r_last_grant;
  logic [LAT_W-1:0]  r_lat_cnt;
  logic [DATA_W-1:0] r_rsp_rdata;
  logic              r_rsp_hit;
  logic [CNT_W-1:0]  r_hit_cnt;
  logic [CNT_W-1:0]  r_miss_cnt;

  logic [N_REQ-1:0]  w_grant;
  logic [IDX_W-1:0]  w_grant_idx;
  logic              w_any_valid;
  logic              w_lat_done;

  rr_arbiter #(
    .N     (N_REQ),
    .IDX_W (IDX_W)
  ) u_rr (
    .req_valid  (req_valid),
    .last_grant (r_last_grant),
    .grant      (w_grant),
    .grant_idx  (w_grant_idx),
    .any_valid  (w_any_valid)
  );

  assign w_lat_done = (r_lat_cnt == LAT_W'(CACHE_LAT - 1));

  // Payload of the requester being granted this cycle.
  always_comb begin
    w_pick                    = '0;
    w_pick.rd_wr              = req_rd_wr[w_grant_idx];
    w_pick.addr[ADDR_W-1:0]   = req_addr[w_grant_idx*ADDR_W +: ADDR_W];
    w_pick.wdata[DATA_W-1:0]  = req_wdata[w_grant_idx*DATA_W +: DATA_W];
    w_pick.owner[IDX_W-1:0]   = w_grant_idx;
  end

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next state and control outputs.
  always_comb begin
    w_state_nxt     = r_state;
    req_ready       = '0;
    cache_req_valid = 1'b0;
    rsp_valid       = '0;
    case (r_state)
      IDLE: begin
        // Gated by reset so ready stays low while reset is held.
        if (!reset) begin
          req_ready = w_grant;
        end
        if (w_any_valid) begin
          w_state_nxt = BUSY;
        end
      end
      BUSY: begin
        cache_req_valid = 1'b1;
        if (w_lat_done) begin
          w_state_nxt = RESP;
        end
      end
      RESP: begin
        for (int i = 0; i < N_REQ; i++) begin
          rsp_valid[i] = (r_req.owner == c_ARB_OWNER_W'(i));
        end
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Request latch, latency counter and response capture.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_req        <= '0;
      r_last_grant <= IDX_W'(N_REQ - 1);
      r_lat_cnt    <= '0;
      r_rsp_rdata  <= '0;
      r_rsp_hit    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any_valid) begin
            r_req        <= w_pick;
            r_last_grant <= w_grant_idx;
            r_lat_cnt    <= '0;
          end
        end
        BUSY: begin
          r_lat_cnt <= r_lat_cnt + 1'b1;
          if (w_lat_done) begin
            r_rsp_hit   <= cache_hit_miss;
            // Writes return no data.
            r_rsp_rdata <= r_req.rd_wr ? '0 : cache_read_data;
          end
        end
        default: ;
      endcase
    end
  end

  // Statistics: a clear in the same cycle as a RESP update takes priority.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
    end else if (clear_stats) begin
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
    end else if (r_state == RESP) begin
      if (r_rsp_hit) begin
        if (r_hit_cnt != '1) begin
          r_hit_cnt <= r_hit_cnt + 1'b1;
        end
      end else begin
        if (r_miss_cnt != '1) begin
          r_miss_cnt <= r_miss_cnt + 1'b1;
        end
      end
    end
  end

  assign rsp_rdata        = r_rsp_rdata;
  assign rsp_hit          = r_rsp_hit;
  assign cache_rd_wr      = r_req.rd_wr;
  assign cache_address    = r_req.addr[ADDR_W-1:0];
  assign cache_write_data = r_req.wdata[DATA_W-1:0];
  assign hit_cnt          = r_hit_cnt;
  assign miss_cnt         = r_miss_cnt;

endmodule
`default_nettype wire

// File: tb/tb_cache_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_cache_port_arbiter
// Purpose  : Directed self-checking bench. Instance A: CACHE_LAT=1,
//            CNT_W=32. Instance B: CACHE_LAT=3, CNT_W=2 (contention and
//            counter saturation). Request payload and cache model are shared.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cache_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  req_rd_wr;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic [31:0] cache_read_data;
  logic        cache_hit_miss;

  logic [1:0]  a_req_valid, a_req_ready, a_rsp_valid;
  logic [31:0] a_rsp_rdata, a_cache_address, a_cache_write_data, a_hit_cnt, a_miss_cnt;
  logic        a_rsp_hit, a_cache_req_valid, a_cache_rd_wr, a_clear;

  logic [1:0]  b_req_valid, b_req_ready, b_rsp_valid;
  logic [31:0] b_rsp_rdata, b_cache_address, b_cache_write_data;
  logic [1:0]  b_hit_cnt, b_miss_cnt;
  logic        b_rsp_hit, b_cache_req_valid, b_cache_rd_wr, b_clear;

  int n_vec  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  cache_port_arbiter #(
    .N_REQ(2), .ADDR_W(32), .DATA_W(32), .CACHE_LAT(1), .CNT_W(32)
  ) dut_a (
    .clk(clk), .reset(reset),
    .req_valid(a_req_valid), .req_ready(a_req_ready), .req_rd_wr(req_rd_wr),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(a_rsp_valid), .rsp_rdata(a_rsp_rdata), .rsp_hit(a_rsp_hit),
    .cache_req_valid(a_cache_req_valid), .cache_rd_wr(a_cache_rd_wr),
    .cache_address(a_cache_address), .cache_write_data(a_cache_write_data),
    .cache_read_data(cache_read_data), .cache_hit_miss(cache_hit_miss),
    .clear_stats(a_clear), .hit_cnt(a_hit_cnt), .miss_cnt(a_miss_cnt)
  );

  cache_port_arbiter #(
    .N_REQ(2), .ADDR_W(32), .DATA_W(32), .CACHE_LAT(3), .CNT_W(2)
  ) dut_b (
    .clk(clk), .reset(reset),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .req_rd_wr(req_rd_wr),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(b_rsp_valid), .rsp_rdata(b_rsp_rdata), .rsp_hit(b_rsp_hit),
    .cache_req_valid(b_cache_req_valid), .cache_rd_wr(b_cache_rd_wr),
    .cache_address(b_cache_address), .cache_write_data(b_cache_write_data),
    .cache_read_data(cache_read_data), .cache_hit_miss(cache_hit_miss),
    .clear_stats(b_clear), .hit_cnt(b_hit_cnt), .miss_cnt(b_miss_cnt)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // One transaction on instance A from requester idx.
  task automatic a_txn(input int idx, input logic rd_wr, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic hit,
                       input logic [31:0] rdata, input logic clr);
    int waited;
    cache_read_data              = rdata;
    cache_hit_miss               = hit;
    req_rd_wr[idx]               = rd_wr;
    req_addr[idx*32 +: 32]       = addr;
    req_wdata[idx*32 +: 32]      = wdata;
    a_req_valid[idx]             = 1'b1;
    #1;
    waited = 0;
    while (a_req_ready[idx] !== 1'b1 && waited < 20) begin
      cyc();
      waited++;
    end
    check("a_ready", a_req_ready, 64'(2'b01 << idx));
    cyc();
    a_req_valid = 2'b00;
    #1;
    check("a_cache_drive", {a_cache_req_valid, a_cache_rd_wr, a_cache_address, a_cache_write_data[29:0]},
          {1'b1, rd_wr, addr, wdata[29:0]});
    cyc();
    if (clr) a_clear = 1'b1;
    check("a_rsp_valid", a_rsp_valid, 64'(2'b01 << idx));
    check("a_rsp_data", {a_rsp_hit, a_rsp_rdata}, {hit, rd_wr ? 32'h0 : rdata});
    cyc();
    a_clear = 1'b0;
    check("a_rsp_pulse_end", {a_rsp_valid, a_cache_req_valid}, 64'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    req_rd_wr = '0; req_addr = '0; req_wdata = '0;
    cache_read_data = '0; cache_hit_miss = 1'b0;
    a_req_valid = '0; b_req_valid = '0; a_clear = 1'b0; b_clear = 1'b0;
    cyc();
    cyc();

    // Reset values.
    check("rst_a_ctrl", {a_req_ready, a_rsp_valid, a_cache_req_valid, a_cache_rd_wr, a_rsp_hit}, 64'h0);
    check("rst_a_bus", {a_cache_address, a_cache_write_data}, 64'h0);
    check("rst_a_cnt", {a_hit_cnt, a_miss_cnt}, 64'h0);
    check("rst_b_ctrl", {b_req_ready, b_rsp_valid, b_cache_req_valid, b_hit_cnt, b_miss_cnt}, 64'h0);
    reset = 1'b0;
    cyc();

    // Single read hit, then a write miss from requester 1.
    a_txn(0, 1'b0, 32'h0004_7a48, 32'h0, 1'b1, 32'hDEAD_BEEF, 1'b0);
    check("read_cnt", {a_hit_cnt, a_miss_cnt}, {32'd1, 32'd0});
    check("rdata_hold", a_rsp_rdata, 64'hDEAD_BEEF);
    a_txn(1, 1'b1, 32'h000c_a55c, 32'h0033_3333, 1'b0, 32'h5555_AAAA, 1'b0);
    check("write_cnt", {a_hit_cnt, a_miss_cnt}, {32'd1, 32'd1});
    check("write_data_bus", a_cache_write_data, 64'h0033_3333);

    // Reset one cycle into BUSY aborts the transaction.
    req_rd_wr[1] = 1'b0;
    a_req_valid = 2'b10;
    #1;
    check("rst_mid_ready", a_req_ready, 64'h2);
    cyc();
    a_req_valid = 2'b00;
    #1;
    check("rst_mid_busy", a_cache_req_valid, 64'h1);
    reset = 1'b1;
    #1;
    check("rst_mid_outputs", {a_cache_req_valid, a_rsp_valid, a_cache_rd_wr, a_cache_address}, 64'h0);
    check("rst_mid_cnt", {a_hit_cnt, a_miss_cnt}, 64'h0);
    cyc();
    check("rst_mid_no_rsp", {a_rsp_valid, a_cache_req_valid, a_rsp_rdata}, 64'h0);
    reset = 1'b0;

    // After reset requester 0 has priority; withdrawing gives no transaction.
    a_req_valid = 2'b11;
    #1;
    check("post_rst_prio", a_req_ready, 64'h1);
    a_req_valid = 2'b00;
    cyc();
    check("withdraw_idle", {a_cache_req_valid, a_rsp_valid}, 64'h0);
    cyc();
    check("withdraw_no_rsp", {a_cache_req_valid, a_rsp_valid}, 64'h0);

    // Statistics: 5 hits, 3 misses, then clear coinciding with a RESP.
    for (int t = 0; t < 5; t++)
      a_txn(t % 2, 1'b0, 32'h0000_1000 + 32'(t), 32'h0, 1'b1, 32'h1000_0000 + 32'(t), 1'b0);
    for (int t = 0; t < 3; t++)
      a_txn((t + 1) % 2, 1'b1, 32'h0000_2000 + 32'(t), 32'h7700_0000 + 32'(t), 1'b0, 32'h0BAD_F00D, 1'b0);
    check("stats_before_clear", {a_hit_cnt, a_miss_cnt}, {32'd5, 32'd3});
    a_txn(0, 1'b0, 32'h0000_3000, 32'h0, 1'b1, 32'h1234_5678, 1'b1);
    check("stats_after_clear", {a_hit_cnt, a_miss_cnt}, 64'h0);

    // Contention on instance B: both requesters always valid, CACHE_LAT=3.
    cache_hit_miss = 1'b1;
    b_req_valid = 2'b11;
    #1;
    for (int t = 0; t < 8; t++) begin
      check("b_grant", b_req_ready, 64'(2'b01 << (t % 2)));
      check("b_hit_cnt", b_hit_cnt, (t < 3) ? 64'(t) : 64'd3);
      for (int c = 1; c <= 4; c++) begin
        cyc();
        if (c < 4)
          check("b_busy", {b_cache_req_valid, b_rsp_valid, b_req_ready}, {1'b1, 2'b00, 2'b00});
        else
          check("b_resp", {b_cache_req_valid, b_rsp_valid}, {1'b0, 2'(2'b01 << (t % 2))});
      end
      cyc();
    end
    b_req_valid = 2'b00;
    #1;
    check("b_saturated", {b_hit_cnt, b_miss_cnt}, {2'd3, 2'd0});
    b_clear = 1'b1;
    cyc();
    b_clear = 1'b0;
    check("b_clear", {b_hit_cnt, b_miss_cnt}, 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
